muxn_reg: RTL and testbench

- Parameterised N:1 single-bit multiplexer used as a routing/selection primitive in the fabric.
- Combinational output O is I[sel], with zero clock latency.
- Also provides a registered copy of the selected bit for pipelined consumers.
- One clock; asynchronous active-high reset clears all state.

---
 rtl/muxn_reg.sv | 92 +++++++++
 tb/tb_muxn_reg.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/muxn_reg.sv
// muxn_reg: parameterised N:1 single-bit multiplexer with a registered copy of
// the selected bit. Out-of-range selects yield 0 rather than aliasing.
// Optional feature macro: MUXN_OOB_FLAG_EN adds a sticky sel_oob output that
// records any clocked out-of-range select until reset.
module muxn_reg #(
    parameter int unsigned IWIDTH = 20,
    parameter int unsigned SWIDTH = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IWIDTH-1:0] I,
    input  logic [SWIDTH-1:0] sel,
    output logic              O,
`ifdef MUXN_OOB_FLAG_EN
    output logic              O_q,
    output logic              sel_oob
`else
    output logic              O_q
`endif
);

    // Elaboration-time legality checks on the configuration.
    if (IWIDTH < 2 || IWIDTH > 256) begin : gen_bad_iwidth
        $error("muxn_reg: IWIDTH must be in 2..256");
    end
    if (SWIDTH < 32 && (64'(1) << SWIDTH) < 64'(IWIDTH)) begin : gen_bad_swidth
        $error("muxn_reg: 2**SWIDTH must be >= IWIDTH");
    end

    logic [31:0] sel_ext;
    logic        sel_in_range;
    logic        o_sel;
    logic        o_reg_d;
    logic        o_reg_q;

    assign sel_ext      = 32'(sel);
    assign sel_in_range = (sel_ext < IWIDTH);

    // Indexed select with an explicit guard: unmatched selects fall through to 0.
    always_comb begin
        o_sel = 1'b0;
        for (int k = 0; k < int'(IWIDTH); k++) begin
            if (sel_ext == 32'(k)) begin
                o_sel = I[k];
            end
        end
    end

    assign O = o_sel;

    // Next-state for the registered copy of the selected bit.
    always_comb begin
        o_reg_d = o_sel;
    end

    // Registered output, cleared asynchronously on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_reg_q <= 1'b0;
        end else begin
            o_reg_q <= o_reg_d;
        end
    end

    assign O_q = o_reg_q;

`ifdef MUXN_OOB_FLAG_EN
    logic oob_d;
    logic oob_q;

    // Sticky flag: once any clocked select is out of range it stays set.
    always_comb begin
        oob_d = oob_q | ~sel_in_range;
    end

    // Flag register, cleared asynchronously on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oob_q <= 1'b0;
        end else begin
            oob_q <= oob_d;
        end
    end

    assign sel_oob = oob_q;
`else
    // Range result only feeds the optional flag; keep it referenced.
    logic unused_range;
    assign unused_range = sel_in_range;
`endif

endmodule

// File: tb/tb_muxn_reg.sv
// Self-checking bench for muxn_reg: directed steps from the test plan followed
// by randomized stimulus, compared against a behavioural reference model.
module tb_muxn_reg;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [19:0] I   = '0;
    logic [4:0]  sel = '0;
    logic        O;
    logic        O_q;
    logic        sel_oob;
    logic [7:0]  I8   = '0;
    logic [2:0]  sel8 = '0;
    logic        O8;
    logic        O_q8;
    logic        sel_oob8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    muxn_reg #(.IWIDTH(20), .SWIDTH(5)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .I       (I),
        .sel     (sel),
        .O       (O),
`ifdef MUXN_OOB_FLAG_EN
        .O_q     (O_q),
        .sel_oob (sel_oob)
`else
        .O_q     (O_q)
`endif
    );

    muxn_reg #(.IWIDTH(8), .SWIDTH(3)) u_dut8 (
        .clk     (clk),
        .rst     (rst),
        .I       (I8),
        .sel     (sel8),
        .O       (O8),
`ifdef MUXN_OOB_FLAG_EN
        .O_q     (O_q8),
        .sel_oob (sel_oob8)
`else
        .O_q     (O_q8)
`endif
    );

`ifndef MUXN_OOB_FLAG_EN
    assign sel_oob  = 1'b0;
    assign sel_oob8 = 1'b0;
`endif

    // Reference: the sel-th bit of the input word, or 0 when sel is past the end.
    function automatic logic ref_mux(input logic [255:0] vec, input int unsigned s,
                                     input int unsigned n);
        if (s >= n) return 1'b0;
        return logic'((vec >> s) & 256'd1);
    endfunction

    // Model of the clocked behaviour: last sampled selection and sticky flag.
    logic m_q, m_q8, m_oob;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q   <= 1'b0;
            m_q8  <= 1'b0;
            m_oob <= 1'b0;
        end else begin
            m_q  <= ref_mux(256'(I), int'(sel), 20);
            m_q8 <= ref_mux(256'(I8), int'(sel8), 8);
            if (int'(sel) >= 20) m_oob <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic check_comb();
        check("O", O, ref_mux(256'(I), int'(sel), 20));
        check("O8", O8, ref_mux(256'(I8), int'(sel8), 8));
    endtask

    task automatic check_oob(input logic exp);
`ifdef MUXN_OOB_FLAG_EN
        check("sel_oob", sel_oob, exp);
`else
        if (exp === 1'bx) checks += 0;
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with no clock edge needed.
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("reset_O_q", O_q, 1'b0);
        check("reset_O", O, 1'b0);
        check_oob(1'b0);
        tick();
        check("reset_hold_O_q", O_q, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Exhaustive select sweep on the spec pattern.
        I = 20'hF57CE;
        for (int k = 0; k < 20; k++) begin
            sel = 5'(k);
            #1;
            check("sweep_O", O, ref_mux(256'(20'hF57CE), k, 20));
        end
        check("sweep_sel19", O, 1'b1);

        // Registered path latency and independence of O from the clock.
        @(negedge clk);
        sel = 5'd3;
        #1;
        check("reg_O", O, 1'b1);
        tick();
        check("reg_O_q", O_q, 1'b1);
        @(negedge clk);
        I = '0;
        #1;
        check("reg_O_now0", O, 1'b0);
        check("reg_O_q_hold", O_q, 1'b1);
        tick();
        check("reg_O_q_next", O_q, 1'b0);

        // Out-of-range selects read as 0 and set the sticky flag.
        @(negedge clk);
        I = 20'hFFFFF;
        for (int k = 20; k < 32; k++) begin
            sel = 5'(k);
            #1;
            check("oob_O", O, 1'b0);
        end
        check_oob(1'b0);
        tick();
        check_oob(1'b1);
        @(negedge clk);
        sel = 5'd5;
        tick();
        check_oob(1'b1);
        check("oob_back_O_q", O_q, 1'b1);

        // Mid-operation reset between edges.
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_O_q", O_q, 1'b0);
        check("midrst_O", O, 1'b1);
        check_oob(1'b0);
        I = 20'hFFFDF;
        #1;
        check("midrst_O_track", O, 1'b0);
        tick();
        check("midrst_O_q_hold", O_q, 1'b0);
        #2;
        rst = 1'b0;
        I = 20'hFFFFF;
        #1;
        check("midrst_rel_O_q", O_q, 1'b0);
        tick();
        check("midrst_first_cap", O_q, 1'b1);

        // Narrow variant.
        I8 = 8'b1100_1110;
        for (int k = 0; k < 8; k++) begin
            sel8 = 3'(k);
            #1;
            check("w8_O", O8, ref_mux(256'(8'b1100_1110), k, 8));
        end
        tick();
        check("w8_O_q", O_q8, m_q8);

        // Randomized stimulus with occasional asynchronous reset pulses.
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            I    = 20'($urandom);
            sel  = 5'($urandom_range(0, 31));
            I8   = 8'($urandom);
            sel8 = 3'($urandom);
            #1;
            check_comb();
            if ($urandom_range(0, 19) == 0) begin
                rst = 1'b1;
                #1;
                check("rnd_rst_O_q", O_q, 1'b0);
                check_oob(1'b0);
                #1;
                rst = 1'b0;
            end
            tick();
            check("rnd_O_q", O_q, m_q);
            check("rnd_O_q8", O_q8, m_q8);
            check_oob(m_oob);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
